// File: rtl/rob_nway.sv
// N-wide reorder buffer: allocates in program order, accepts out-of-order completions,
// retires in order, forwards completed values by physical register, and flushes on mispredict.
module rob_nway #(
  parameter  int ROB_SIZE   = 16,
  parameter  int DISP_W     = 2,
  parameter  int CMPL_W     = 3,
  parameter  int RET_W      = 2,
  parameter  int NUM_P_REGS = 64,
  parameter  int WORD_SIZE  = 32,
  parameter  int PC_SIZE    = 32,
  localparam int PR_W       = $clog2(NUM_P_REGS),
  localparam int IDX_W      = $clog2(ROB_SIZE),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DISP_W-1:0]                disp_valid_i,
  output logic                             disp_ready_o,
  input  logic [DISP_W*PR_W-1:0]           disp_dest_i,
  input  logic [DISP_W*PR_W-1:0]           disp_old_dest_i,
  input  logic [DISP_W-1:0]                disp_regwr_i,
  input  logic [DISP_W*PC_SIZE-1:0]        disp_pc_i,
  output logic [DISP_W*IDX_W-1:0]          disp_idx_o,
  input  logic [CMPL_W-1:0]                cmpl_valid_i,
  input  logic [CMPL_W*IDX_W-1:0]          cmpl_idx_i,
  input  logic [CMPL_W*PC_SIZE-1:0]        cmpl_pc_i,
  input  logic [CMPL_W*WORD_SIZE-1:0]      cmpl_val_i,
  input  logic [CMPL_W-1:0]                cmpl_mispred_i,
  input  logic [CMPL_W*PC_SIZE-1:0]        cmpl_target_i,
  output logic                             cmpl_err_o,
  output logic [NUM_P_REGS-1:0]            fwd_ready_o,
  output logic [NUM_P_REGS*WORD_SIZE-1:0]  fwd_val_o,
  output logic [RET_W-1:0]                 ret_valid_o,
  output logic [RET_W-1:0]                 ret_regwr_o,
  output logic [RET_W*PR_W-1:0]            ret_dest_o,
  output logic [RET_W*PR_W-1:0]            ret_old_dest_o,
  output logic [RET_W*WORD_SIZE-1:0]       ret_val_o,
  output logic                             flush_o,
  output logic [PC_SIZE-1:0]               redirect_pc_o,
  output logic [CNT_W-1:0]                 count_o
);

  logic [ROB_SIZE-1:0]   valid_q, valid_d, done_q, done_d, regwr_q, regwr_d, mis_q, mis_d;
  logic [PC_SIZE-1:0]    pc_q   [ROB_SIZE];
  logic [PC_SIZE-1:0]    pc_d   [ROB_SIZE];
  logic [PC_SIZE-1:0]    tgt_q  [ROB_SIZE];
  logic [PC_SIZE-1:0]    tgt_d  [ROB_SIZE];
  logic [PR_W-1:0]       dest_q [ROB_SIZE];
  logic [PR_W-1:0]       dest_d [ROB_SIZE];
  logic [PR_W-1:0]       old_q  [ROB_SIZE];
  logic [PR_W-1:0]       old_d  [ROB_SIZE];
  logic [WORD_SIZE-1:0]  val_q  [ROB_SIZE];
  logic [WORD_SIZE-1:0]  val_d  [ROB_SIZE];

  logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_P_REGS-1:0] fwd_rdy_q, fwd_rdy_d;
  logic [WORD_SIZE-1:0]  fwd_val_q [NUM_P_REGS];
  logic [WORD_SIZE-1:0]  fwd_val_d [NUM_P_REGS];

  logic [RET_W-1:0]           ret_valid_q, ret_valid_d, ret_regwr_q, ret_regwr_d;
  logic [RET_W*PR_W-1:0]      ret_dest_q, ret_dest_d, ret_old_q, ret_old_d;
  logic [RET_W*WORD_SIZE-1:0] ret_val_q, ret_val_d;
  logic                       err_q, err_d, flush_q, flush_d;
  logic [PC_SIZE-1:0]         redirect_q, redirect_d;

  logic                  disp_ready_s, disp_ok_s, stop_s, legal_s, take_s;
  logic [IDX_W-1:0]      ridx_s, cidx_s, tidx_s;
  logic [CNT_W-1:0]      ret_n_s, alloc_s;

  // Credit is based on the registered count only, so retires in the same cycle do not help.
  assign disp_ready_s = (count_q <= CNT_W'(ROB_SIZE - DISP_W));

  // Next-state: retire scan first (it decides flush), then completions, then allocation.
  always_comb begin
    valid_d = valid_q;  done_d = done_q;  regwr_d = regwr_q;  mis_d = mis_q;
    pc_d = pc_q;  tgt_d = tgt_q;  dest_d = dest_q;  old_d = old_q;  val_d = val_q;
    fwd_rdy_d = fwd_rdy_q;
    fwd_val_d = fwd_val_q;
    ret_valid_d = '0;  ret_regwr_d = '0;  ret_dest_d = '0;  ret_old_d = '0;  ret_val_d = '0;
    err_d = 1'b0;  flush_d = 1'b0;  redirect_d = redirect_q;
    stop_s = 1'b0;  legal_s = 1'b0;  take_s = 1'b0;
    ridx_s = '0;  cidx_s = '0;  tidx_s = '0;
    ret_n_s = '0;  alloc_s = '0;
    disp_ok_s = 1'b0;

    for (int s = 0; s < RET_W; s++) begin
      ridx_s = head_q + IDX_W'(s);
      if (!stop_s && valid_q[ridx_s] && done_q[ridx_s]) begin
        ret_valid_d[s] = 1'b1;
        ret_regwr_d[s] = regwr_q[ridx_s];
        ret_dest_d[s*PR_W +: PR_W] = dest_q[ridx_s];
        ret_old_d[s*PR_W +: PR_W]  = old_q[ridx_s];
        ret_val_d[s*WORD_SIZE +: WORD_SIZE] = val_q[ridx_s];
        valid_d[ridx_s] = 1'b0;
        fwd_rdy_d[dest_q[ridx_s]] = fwd_rdy_d[dest_q[ridx_s]] & ~regwr_q[ridx_s];
        ret_n_s = ret_n_s + CNT_W'(1);
        // A mispredicted branch is the last instruction retired this cycle.
        stop_s = mis_q[ridx_s];
        flush_d = flush_d | mis_q[ridx_s];
        redirect_d = mis_q[ridx_s] ? tgt_q[ridx_s] : redirect_d;
      end else begin
        stop_s = 1'b1;
      end
    end

    for (int p = 0; p < CMPL_W; p++) begin
      cidx_s  = cmpl_idx_i[p*IDX_W +: IDX_W];
      legal_s = valid_q[cidx_s] && (pc_q[cidx_s] == cmpl_pc_i[p*PC_SIZE +: PC_SIZE]);
      if (cmpl_valid_i[p] && !flush_d && legal_s) begin
        done_d[cidx_s] = 1'b1;
        val_d[cidx_s]  = cmpl_val_i[p*WORD_SIZE +: WORD_SIZE];
        mis_d[cidx_s]  = cmpl_mispred_i[p];
        tgt_d[cidx_s]  = cmpl_target_i[p*PC_SIZE +: PC_SIZE];
        fwd_rdy_d[dest_q[cidx_s]] = fwd_rdy_d[dest_q[cidx_s]] | regwr_q[cidx_s];
        fwd_val_d[dest_q[cidx_s]] = regwr_q[cidx_s] ? cmpl_val_i[p*WORD_SIZE +: WORD_SIZE]
                                                    : fwd_val_d[dest_q[cidx_s]];
      end else begin
        err_d = err_d | (cmpl_valid_i[p] & ~flush_d);
      end
    end

    disp_ok_s = disp_ready_s & ~flush_d;
    for (int k = 0; k < DISP_W; k++) begin
      tidx_s = tail_q + IDX_W'(k);
      take_s = disp_ok_s & disp_valid_i[k];
      valid_d[tidx_s] = valid_d[tidx_s] | take_s;
      done_d[tidx_s]  = done_d[tidx_s] & ~take_s;
      mis_d[tidx_s]   = mis_d[tidx_s] & ~take_s;
      regwr_d[tidx_s] = take_s ? disp_regwr_i[k] : regwr_d[tidx_s];
      pc_d[tidx_s]    = take_s ? disp_pc_i[k*PC_SIZE +: PC_SIZE] : pc_d[tidx_s];
      dest_d[tidx_s]  = take_s ? disp_dest_i[k*PR_W +: PR_W] : dest_d[tidx_s];
      old_d[tidx_s]   = take_s ? disp_old_dest_i[k*PR_W +: PR_W] : old_d[tidx_s];
      alloc_s = alloc_s + CNT_W'(take_s);
    end

    head_d = head_q + IDX_W'(ret_n_s);
    if (flush_d) begin
      valid_d   = '0;
      fwd_rdy_d = '0;
      tail_d    = head_d;
      count_d   = '0;
    end else begin
      tail_d  = tail_q + IDX_W'(alloc_s);
      count_d = count_q + alloc_s - ret_n_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;  done_q <= '0;  regwr_q <= '0;  mis_q <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        pc_q[e] <= '0;  tgt_q[e] <= '0;  dest_q[e] <= '0;  old_q[e] <= '0;  val_q[e] <= '0;
      end
      for (int r = 0; r < NUM_P_REGS; r++) begin
        fwd_val_q[r] <= '0;
      end
      head_q <= '0;  tail_q <= '0;  count_q <= '0;  fwd_rdy_q <= '0;
      ret_valid_q <= '0;  ret_regwr_q <= '0;  ret_dest_q <= '0;  ret_old_q <= '0;  ret_val_q <= '0;
      err_q <= 1'b0;  flush_q <= 1'b0;  redirect_q <= '0;
    end else begin
      valid_q <= valid_d;  done_q <= done_d;  regwr_q <= regwr_d;  mis_q <= mis_d;
      pc_q <= pc_d;  tgt_q <= tgt_d;  dest_q <= dest_d;  old_q <= old_d;  val_q <= val_d;
      fwd_val_q <= fwd_val_d;
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;  fwd_rdy_q <= fwd_rdy_d;
      ret_valid_q <= ret_valid_d;  ret_regwr_q <= ret_regwr_d;  ret_dest_q <= ret_dest_d;
      ret_old_q <= ret_old_d;  ret_val_q <= ret_val_d;
      err_q <= err_d;  flush_q <= flush_d;  redirect_q <= redirect_d;
    end
  end

  // Output packing.
  always_comb begin
    disp_idx_o = '0;
    fwd_val_o  = '0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_idx_o[k*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
    end
    for (int r = 0; r < NUM_P_REGS; r++) begin
      fwd_val_o[r*WORD_SIZE +: WORD_SIZE] = fwd_val_q[r];
    end
  end

  assign disp_ready_o   = disp_ready_s;
  assign cmpl_err_o     = err_q;
  assign fwd_ready_o    = fwd_rdy_q;
  assign ret_valid_o    = ret_valid_q;
  assign ret_regwr_o    = ret_regwr_q;
  assign ret_dest_o     = ret_dest_q;
  assign ret_old_dest_o = ret_old_q;
  assign ret_val_o      = ret_val_q;
  assign flush_o        = flush_q;
  assign redirect_pc_o  = redirect_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: queue-based program-order model, per-cycle output comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_nway;
  localparam int RS = 16, DW = 2, CW = 3, RW = 2, NP = 64, WS = 32, PS = 32, PRW = 6, IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0]      disp_valid, disp_regwr;
  logic               disp_ready;
  logic [DW*PRW-1:0]  disp_dest, disp_old;
  logic [DW*PS-1:0]   disp_pc;
  logic [DW*IW-1:0]   disp_idx;
  logic [CW-1:0]      cmpl_valid, cmpl_mis;
  logic [CW*IW-1:0]   cmpl_idx;
  logic [CW*PS-1:0]   cmpl_pc, cmpl_tgt;
  logic [CW*WS-1:0]   cmpl_val;
  logic               cmpl_err, flush;
  logic [NP-1:0]      fwd_ready;
  logic [NP*WS-1:0]   fwd_val;
  logic [RW-1:0]      ret_valid, ret_regwr;
  logic [RW*PRW-1:0]  ret_dest, ret_old;
  logic [RW*WS-1:0]   ret_val;
  logic [PS-1:0]      redirect_pc;
  logic [IW:0]        count;

  rob_nway dut (
    .clk_i(clk), .rst_i(rst),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_dest_i(disp_dest),
    .disp_old_dest_i(disp_old), .disp_regwr_i(disp_regwr), .disp_pc_i(disp_pc),
    .disp_idx_o(disp_idx),
    .cmpl_valid_i(cmpl_valid), .cmpl_idx_i(cmpl_idx), .cmpl_pc_i(cmpl_pc), .cmpl_val_i(cmpl_val),
    .cmpl_mispred_i(cmpl_mis), .cmpl_target_i(cmpl_tgt), .cmpl_err_o(cmpl_err),
    .fwd_ready_o(fwd_ready), .fwd_val_o(fwd_val),
    .ret_valid_o(ret_valid), .ret_regwr_o(ret_regwr), .ret_dest_o(ret_dest),
    .ret_old_dest_o(ret_old), .ret_val_o(ret_val),
    .flush_o(flush), .redirect_pc_o(redirect_pc), .count_o(count)
  );

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [5:0]  dest;
    logic [5:0]  old;
    logic        regwr;
    logic        done;
    logic        mis;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  // Model: live instructions in program order, oldest first.
  ent_t        rob[$];
  int          head;
  logic [63:0] m_fwd_rdy;
  logic [31:0] m_fwd_val [NP];
  int          e_count;
  logic [1:0]  e_ret_v, e_ret_w;
  logic [5:0]  e_rd [RW];
  logic [5:0]  e_ro [RW];
  logic [31:0] e_rval [RW];
  logic        e_err, e_flush;
  logic [31:0] e_redir;

  int checks = 0, failures = 0, seq = 0, dut_ret = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    rob.delete();
    head = 0;
    m_fwd_rdy = '0;
    for (int r = 0; r < NP; r++) m_fwd_val[r] = '0;
    e_ret_v = '0; e_ret_w = '0; e_err = 1'b0; e_flush = 1'b0; e_redir = '0; e_count = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_step();
    int n, pre, tail0, pos, ci;
    bit fl;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    pre = rob.size();
    tail0 = (head + pre) % RS;
    n = 0; fl = 1'b0;
    for (int s = 0; s < RW; s++) begin
      if (fl || s >= pre) break;
      if (!rob[s].done) break;
      n++;
      fl = rob[s].mis;
    end
    e_ret_v = '0;
    for (int s = 0; s < n; s++) begin
      e_ret_v[s] = 1'b1; e_ret_w[s] = rob[s].regwr;
      e_rd[s] = rob[s].dest; e_ro[s] = rob[s].old; e_rval[s] = rob[s].val;
    end
    e_flush = fl;
    e_err = 1'b0;
    if (fl) begin
      e_redir = rob[n-1].tgt;
      head = (head + n) % RS;
      rob.delete();
      m_fwd_rdy = '0;
    end else begin
      for (int s = 0; s < n; s++) if (rob[s].regwr) m_fwd_rdy[rob[s].dest] = 1'b0;
      for (int p = 0; p < CW; p++) begin
        if (cmpl_valid[p]) begin
          ci = int'(cmpl_idx[p*IW +: IW]);
          pos = (ci - head + RS) % RS;
          if (pos < pre && rob[pos].pc == cmpl_pc[p*PS +: PS]) begin
            e = rob[pos];
            e.done = 1'b1; e.val = cmpl_val[p*WS +: WS];
            e.mis = cmpl_mis[p]; e.tgt = cmpl_tgt[p*PS +: PS];
            rob[pos] = e;
            if (e.regwr) begin
              m_fwd_rdy[e.dest] = 1'b1;
              m_fwd_val[e.dest] = e.val;
            end
          end else begin
            e_err = 1'b1;
          end
        end
      end
      for (int s = 0; s < n; s++) e = rob.pop_front();
      head = (head + n) % RS;
      if (RS - pre >= DW) begin
        for (int k = 0; k < DW; k++) begin
          if (disp_valid[k]) begin
            e.idx = (tail0 + k) % RS; e.pc = disp_pc[k*PS +: PS];
            e.dest = disp_dest[k*PRW +: PRW]; e.old = disp_old[k*PRW +: PRW];
            e.regwr = disp_regwr[k]; e.done = 1'b0; e.mis = 1'b0; e.val = '0; e.tgt = '0;
            rob.push_back(e);
          end
        end
      end
    end
    e_count = rob.size();
  endfunction

  // Compare every DUT output against the model shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("count", 64'(count), 64'(e_count));
      check("disp_ready", 64'(disp_ready), 64'((RS - e_count) >= DW));
      for (int k = 0; k < DW; k++)
        check("disp_idx", 64'(disp_idx[k*IW +: IW]), 64'((head + e_count + k) % RS));
      check("ret_valid", 64'(ret_valid), 64'(e_ret_v));
      for (int s = 0; s < RW; s++) begin
        if (e_ret_v[s]) begin
          check("ret_regwr", 64'(ret_regwr[s]), 64'(e_ret_w[s]));
          check("ret_dest", 64'(ret_dest[s*PRW +: PRW]), 64'(e_rd[s]));
          check("ret_old", 64'(ret_old[s*PRW +: PRW]), 64'(e_ro[s]));
          check("ret_val", 64'(ret_val[s*WS +: WS]), 64'(e_rval[s]));
        end
        if (ret_valid[s]) dut_ret++;
      end
      check("cmpl_err", 64'(cmpl_err), 64'(e_err));
      check("flush", 64'(flush), 64'(e_flush));
      if (e_flush) check("redirect", 64'(redirect_pc), 64'(e_redir));
      check("fwd_ready", fwd_ready, m_fwd_rdy);
      for (int r = 0; r < NP; r++)
        if (m_fwd_rdy[r]) check("fwd_val", 64'(fwd_val[r*WS +: WS]), 64'(m_fwd_val[r]));
    end
  end

  always @(posedge clk)
    if (!rst) assert (disp_valid != 2'b10) else $error("non-contiguous dispatch mask");

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    disp_valid = '0; disp_regwr = '0; disp_dest = '0; disp_old = '0; disp_pc = '0;
    cmpl_valid = '0; cmpl_idx = '0; cmpl_pc = '0; cmpl_val = '0; cmpl_mis = '0; cmpl_tgt = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
    idle_inputs();
  endtask

  task automatic disp(input int n);
    for (int k = 0; k < n; k++) begin
      disp_valid[k] = 1'b1;
      disp_regwr[k] = (seq % 5) != 0;
      disp_dest[k*PRW +: PRW] = 6'(seq);
      disp_old[k*PRW +: PRW]  = 6'(seq + 32);
      disp_pc[k*PS +: PS]     = 32'h1000 + 32'(seq * 4);
      seq++;
    end
  endtask

  task automatic cmpl(input int p, input int idx, input logic [31:0] pc, input logic [31:0] val,
                      input logic mis, input logic [31:0] tgt);
    cmpl_valid[p] = 1'b1;
    cmpl_idx[p*IW +: IW] = 4'(idx);
    cmpl_pc[p*PS +: PS] = pc;
    cmpl_val[p*WS +: WS] = val;
    cmpl_mis[p] = mis;
    cmpl_tgt[p*PS +: PS] = tgt;
  endtask

  function automatic logic [31:0] pc_at(input int idx);
    int pos;
    pos = (idx - head + RS) % RS;
    if (pos < rob.size()) return rob[pos].pc;
    return 32'hDEAD0000;
  endfunction

  task automatic complete_oldest(input int ports, input bit mis_en);
    int p;
    p = 0;
    for (int i = 0; i < rob.size(); i++) begin
      if (!rob[i].done && p < ports) begin
        cmpl(p, rob[i].idx, rob[i].pc, $urandom,
             mis_en && ($urandom_range(0, 24) == 0), $urandom);
        p++;
      end
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (rob.size() > 0 && cyc < 100) begin
      complete_oldest(CW, 1'b0);
      step();
      cyc++;
    end
    check("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    int r0, nd, j, idx, rr;
    logic [31:0] pc;
    int inc[$];

    idle_inputs();
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    step(); step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(disp_ready), 64'd1);
    check("rst_idx1", 64'(disp_idx[7:4]), 64'd1);
    check("rst_ret", 64'(ret_valid), 64'd0);
    rst = 1'b0;
    step();

    // Fill to full with two per cycle, then try once more.
    for (int i = 0; i < 7; i++) begin disp(2); step(); end
    check("fill14_count", 64'(count), 64'd14);
    check("fill14_ready", 64'(disp_ready), 64'd1);
    disp(2); step();
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(disp_ready), 64'd0);
    disp(2); step();
    check("full9_count", 64'(count), 64'd16);
    check("full9_idx0", 64'(disp_idx[3:0]), 64'd0);
    check("full9_idx1", 64'(disp_idx[7:4]), 64'd1);
    drain();

    // Reset with five live entries, two of them completed behind an incomplete head.
    disp(2); step(); disp(2); step(); disp(1); step();
    cmpl(0, (head + 1) % RS, pc_at((head + 1) % RS), 32'h11, 1'b0, 32'h0);
    cmpl(1, (head + 2) % RS, pc_at((head + 2) % RS), 32'h12, 1'b0, 32'h0);
    step(); step();
    check("live5_count", 64'(count), 64'd5);
    rst = 1'b1;
    #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_ret", 64'(ret_valid), 64'd0);
    check("midrst_fwd", fwd_ready, 64'd0);
    check("midrst_ready", 64'(disp_ready), 64'd1);
    step();
    rst = 1'b0;
    step();

    // Out-of-order completion, in-order retire.
    disp(2); step(); disp(2); step();
    cmpl(0, 2, pc_at(2), 32'h22, 1'b0, 32'h0); step();
    cmpl(0, 0, pc_at(0), 32'h20, 1'b0, 32'h0); step();
    step();
    check("r0_valid", 64'(ret_valid), 64'd1);
    check("r0_val", 64'(ret_val[31:0]), 64'h20);
    cmpl(0, 1, pc_at(1), 32'h21, 1'b0, 32'h0); step();
    step();
    check("r12_valid", 64'(ret_valid), 64'd3);
    check("r12_val0", 64'(ret_val[31:0]), 64'h21);
    check("r12_val1", 64'(ret_val[63:32]), 64'h22);

    // Wrong PC on idx3.
    cmpl(0, 3, pc_at(3) ^ 32'h4, 32'h33, 1'b0, 32'h0); step();
    check("err_hi", 64'(cmpl_err), 64'd1);
    step();
    check("err_lo", 64'(cmpl_err), 64'd0);
    check("err_live", 64'(count), 64'd1);
    drain();

    // Mispredict at head 14 with six live entries.
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 7; i++) begin disp(2); step(); end
    drain();
    for (int i = 0; i < 3; i++) begin disp(2); step(); end
    check("mp_live", 64'(count), 64'd6);
    cmpl(0, 14, pc_at(14), 32'h14, 1'b1, 32'h400);
    cmpl(1, 15, pc_at(15), 32'h15, 1'b0, 32'h0);
    step();
    step();
    check("mp_ret", 64'(ret_valid), 64'd1);
    check("mp_retval", 64'(ret_val[31:0]), 64'h14);
    check("mp_flush", 64'(flush), 64'd1);
    check("mp_redirect", 64'(redirect_pc), 64'h400);
    check("mp_count", 64'(count), 64'd0);
    check("mp_idx0", 64'(disp_idx[3:0]), 64'd15);
    step();
    check("mp_flush_lo", 64'(flush), 64'd0);

    // 40 single-issue instructions wrapping the buffer.
    r0 = dut_ret;
    for (int i = 0; i < 40; i++) begin
      disp(1);
      complete_oldest(1, 1'b0);
      step();
    end
    drain();
    check("wrap_retired", 64'(dut_ret - r0), 64'd40);

    // Randomized traffic with occasional errors, mispredicts and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      nd = $urandom_range(0, 2);
      disp(nd);
      inc = {};
      for (int q = 0; q < rob.size(); q++) if (!rob[q].done) inc.push_back(q);
      for (int p = 0; p < CW; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (inc.size() > 0) begin
            j = inc[$urandom_range(0, inc.size() - 1)];
            idx = rob[j].idx; pc = rob[j].pc;
          end else begin
            idx = $urandom_range(0, RS - 1); pc = pc_at(idx);
          end
          rr = $urandom_range(0, 39);
          if (rr == 0) pc = pc ^ 32'h4;
          if (rr == 1) begin
            idx = (head + rob.size()) % RS;
            pc = pc_at(idx);
          end
          cmpl(p, idx, pc, $urandom, $urandom_range(0, 24) == 0, $urandom);
        end
      end
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
